// File: rtl/vmicro16_cluster_apb_bridge_if.sv
// APB signal bundle shared by the cluster-side and SoC-side ports of the cluster bridge.
// The master modport issues requests; the slave modport answers them with pready/prdata.
interface vmicro16_cluster_apb_bridge_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/vmicro16_cluster_apb_bridge.sv
// Registered APB bridge: cluster access phase -> fresh SETUP/ACCESS downstream -> one-cycle S pready (3 cycles zero-wait).
// Cluster waits in ACCESS until RESP; VMICRO16_APB_BRIDGE_TIMEOUT_EN adds an ACCESS abort after TIMEOUT_CYCLES.
module vmicro16_cluster_apb_bridge #(
  parameter int                  BUS_WIDTH      = 16,
  parameter int                  DATA_WIDTH     = 16,
  parameter int                  ID_WIDTH       = 2,
  parameter logic [ID_WIDTH-1:0] CLUSTER_ID     = '0,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  vmicro16_cluster_apb_bridge_if.slave  s_apb,
  vmicro16_cluster_apb_bridge_if.master m_apb,
  output logic [ID_WIDTH-1:0]           m_pid_o,
  output logic                          timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                state_q,   state_d;
  logic [BUS_WIDTH-1:0]  paddr_q,   paddr_d;
  logic                  pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic [ID_WIDTH-1:0]   pid_q,     pid_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
  logic                  pready_q,  pready_d;

`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q,  timeout_d;
`else
  logic [7:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 8'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pid_d     = pid_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Only the cluster's access phase starts a transfer; its setup phase is ignored.
        if (s_apb.psel && s_apb.penable) begin
          paddr_d   = s_apb.paddr;
          pwrite_d  = s_apb.pwrite;
          pwdata_d  = s_apb.pwdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pid_d     = CLUSTER_ID;
          state_d   = ST_SETUP;
`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (m_apb.pready) begin
          prdata_d  = pwrite_q ? '0 : m_apb.prdata;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pid_d     = '0;
          pready_d  = 1'b1;
          state_d   = ST_RESP;
        end
`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
        // This cycle is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
        else if (wait_cnt_q == TO_LAST) begin
          prdata_d  = '1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pid_d     = '0;
          pready_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pid_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pid_q     <= pid_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
    end
  end

`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign m_apb.paddr   = paddr_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_pid_o       = pid_q;
  assign s_apb.prdata  = prdata_q;
  assign s_apb.pready  = pready_q;

endmodule

// File: tb/tb_vmicro16_cluster_apb_bridge.sv
// Bench for the cluster APB bridge: transaction-timeline model checked every cycle, plus literal checks.
// Build with VMICRO16_APB_BRIDGE_TIMEOUT_EN to also exercise the ACCESS abort path.
module tb_vmicro16_cluster_apb_bridge;
  localparam int             BW  = 16;
  localparam int             DW  = 16;
  localparam int             IW  = 2;
  localparam logic [IW-1:0]  CID = 2'd2;
  localparam int             TO  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vmicro16_cluster_apb_bridge_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) s_if ();
  vmicro16_cluster_apb_bridge_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) m_if ();
  logic [IW-1:0] m_pid;
  logic          timeout;

  vmicro16_cluster_apb_bridge #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .CLUSTER_ID(CID), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_apb(s_if), .m_apb(m_if),
    .m_pid_o(m_pid), .timeout_o(timeout)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rst_edge = 1'b1;

  // Current transaction as seen by the model: capture edge tn, tacc ACCESS cycles, then one RESP cycle.
  bit          act = 1'b0;
  int          tn = 0, tacc = 0;
  bit          tabort = 1'b0, twr = 1'b0;
  logic [15:0] taddr = '0, twdata = '0, tresult = '0;
  logic [15:0] hold_prdata = '0;
  bit          hold_to = 1'b0;
  int          last_rdy = -1;
  int          setup_cnt = 0;

  // SoC-side responder settings for the current transaction.
  int          cur_w = 0;
  logic [15:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_edge = reset;
  end

  // Every-cycle compare against the transaction timeline.
  initial begin
    int rel;
    bit e_sel, e_en, e_rdy;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        e_sel = 1'b0; e_en = 1'b0; e_rdy = 1'b0;
        if (rst_edge) begin
          hold_prdata = '0;
          hold_to     = 1'b0;
          chk("rst_paddr", m_if.paddr, 0);
          chk("rst_pwrite", m_if.pwrite, 0);
          chk("rst_pwdata", m_if.pwdata, 0);
        end else begin
          rel   = act ? (cyc - tn) : -1;
          e_sel = (rel >= 0) && (rel <= tacc);
          e_en  = (rel >= 1) && (rel <= tacc);
          e_rdy = (rel == tacc + 1);
          if (e_rdy) begin
            hold_prdata = tresult;
            if (tabort) hold_to = 1'b1;
          end
          if (e_sel) begin
            chk("m_paddr", m_if.paddr, taddr);
            chk("m_pwrite", m_if.pwrite, twr);
            chk("m_pwdata", m_if.pwdata, twdata);
          end
        end
        chk("m_psel", m_if.psel, e_sel);
        chk("m_penable", m_if.penable, e_en);
        chk("m_pid", m_pid, e_sel ? CID : '0);
        chk("s_pready", s_if.pready, e_rdy);
        chk("s_prdata", s_if.prdata, hold_prdata);
        chk("timeout", timeout, hold_to);
        if (s_if.pready === 1'b1) last_rdy = cyc;
        if (m_if.psel === 1'b1 && m_if.penable === 1'b0) setup_cnt++;
      end
    end
  end

  // SoC slave: pready after cur_w ACCESS wait cycles, random spurious pready elsewhere.
  initial begin
    int cnt;
    cnt = 0;
    m_if.pready = 1'b0;
    m_if.prdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_if.psel && m_if.penable) begin
        m_if.pready = (cnt == cur_w);
        m_if.prdata = (cnt == cur_w) ? cur_rdata : 16'($urandom);
        cnt++;
      end else begin
        cnt = 0;
        m_if.pready = ($urandom_range(0, 2) == 0);
        m_if.prdata = 16'($urandom);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cluster setup phase for one cycle, then access phase; loads the model.
  task automatic start_txn(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int w, output int acc);
    bit ab;
    s_if.psel = 1'b1; s_if.penable = 1'b0;
    s_if.paddr = addr; s_if.pwrite = wr; s_if.pwdata = wdata;
    @(posedge clk);
    #1;
    acc = w + 1;
    ab  = 1'b0;
`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
    if (w >= TO) begin
      acc = TO;
      ab  = 1'b1;
    end
`endif
    cur_w = w; cur_rdata = rdata;
    tn = cyc + 1; tacc = acc; tabort = ab; twr = wr; taddr = addr; twdata = wdata;
    tresult = ab ? 16'hFFFF : (wr ? 16'h0000 : rdata);
    act = 1'b1;
    s_if.penable = 1'b1;
  endtask

  task automatic do_txn(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                        input logic [15:0] rdata, input int w, input bit scr);
    int acc;
    start_txn(addr, wr, wdata, rdata, w, acc);
    // Cluster samples S_PREADY at the edge after RESP and releases the bus.
    repeat (acc + 3) begin
      @(posedge clk);
      #1;
      if (scr) begin
        s_if.paddr  = 16'($urandom);
        s_if.pwdata = 16'($urandom);
        s_if.pwrite = 1'($urandom);
      end
    end
    s_if.psel = 1'b0;
    s_if.penable = 1'b0;
  endtask

  initial begin
    int s0, acc;
    reset = 1'b1;
    s_if.psel = 1'b0; s_if.penable = 1'b0; s_if.pwrite = 1'b0;
    s_if.paddr = '0; s_if.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    do_txn(16'h0040, 1'b0, 16'h0000, 16'hBEEF, 0, 1'b0);
    chk("t1_latency", last_rdy - tn, 2);
    chk("t1_prdata", s_if.prdata, 16'hBEEF);
    idle(1);

    do_txn(16'h0012, 1'b1, 16'h1234, 16'hDEAD, 3, 1'b1);
    chk("t2_latency", last_rdy - tn, 5);
    chk("t2_prdata", s_if.prdata, 16'h0000);
    idle(1);

    s0 = setup_cnt;
    do_txn(16'h0001, 1'b0, 16'h0000, 16'h1111, 0, 1'b0);
    do_txn(16'h0002, 1'b0, 16'h0000, 16'h2222, 0, 1'b0);
    chk("t6_setups", setup_cnt - s0, 2);
    chk("t6_prdata", s_if.prdata, 16'h2222);
    idle(1);

    // Reset in the middle of ACCESS abandons the transfer.
    start_txn(16'h0077, 1'b0, 16'h0000, 16'h7777, 10, acc);
    idle(3);
    reset = 1'b1;
    s_if.psel = 1'b0; s_if.penable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    act = 1'b0;
    chk("t4_psel", m_if.psel, 0);
    chk("t4_pready", s_if.pready, 0);
    idle(3);
    chk("t4_no_resp", s_if.pready, 0);
    do_txn(16'h0050, 1'b0, 16'h0000, 16'h5A5A, 1, 1'b0);
    chk("t4_after_prdata", s_if.prdata, 16'h5A5A);
    idle(1);

`ifdef VMICRO16_APB_BRIDGE_TIMEOUT_EN
    do_txn(16'h0033, 1'b0, 16'h0000, 16'h3333, TO - 1, 1'b0);
    chk("t5_limit_win_prdata", s_if.prdata, 16'h3333);
    chk("t5_limit_win_to", timeout, 0);
    idle(1);
    do_txn(16'h0034, 1'b0, 16'h0000, 16'h4444, 20, 1'b0);
    chk("t5_abort_latency", last_rdy - tn, 5);
    chk("t5_abort_prdata", s_if.prdata, 16'hFFFF);
    chk("t5_abort_to", timeout, 1);
    idle(1);
    do_txn(16'h0035, 1'b1, 16'h5555, 16'h0000, 0, 1'b0);
    chk("t5_sticky_to", timeout, 1);
    chk("t5_sticky_prdata", s_if.prdata, 16'h0000);
    idle(1);
`endif

    for (int i = 0; i < 40; i++) begin
      do_txn(16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 6), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
